// File: rtl/pre_norm_pipe.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pre_norm_pipe
//   Floating-point add/subtract pre-normalisation, two pipeline stages with a
//   valid/ready handshake on both sides.
//     Stage 1: decode both operands, compare magnitudes, swap so the larger
//              operand is "A", and resolve sign / NaN sign / zero sign.
//     Stage 2: right-align the smaller fraction to the larger exponent,
//              folding every bit shifted out into the sticky LSB.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid / in_ready       operand-pair handshake
//   opa, opb                  {sign, exp, frac} operands, W = 1+EXP_W+FRAC_W
//   add                       1 = add, 0 = subtract
//   rmode                     rounding mode (2'b11 = toward minus infinity)
//   out_valid / out_ready     result handshake
//   fracta_out, fractb_out    {hidden, frac, guard, round, sticky} larger/smaller
//   exp_dn_out                common (larger) exponent, 0 on exact cancellation
//   sign, nan_sign, result_zero_sign, fasu_op   per-result flags
// ---------------------------------------------------------------------------
module pre_norm_pipe #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    localparam int W     = 1 + EXP_W + FRAC_W,
    localparam int FW    = FRAC_W + 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      opa,
    input  logic [W-1:0]      opb,
    input  logic              add,
    input  logic [1:0]        rmode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FW-1:0]     fracta_out,
    output logic [FW-1:0]     fractb_out,
    output logic [EXP_W-1:0]  exp_dn_out,
    output logic              sign,
    output logic              nan_sign,
    output logic              result_zero_sign,
    output logic              fasu_op
);

    // Right shift with sticky: every bit shifted out is ORed into the LSB.
    // Shifts of the full width or more leave only the sticky bit.
    function automatic logic [FW-1:0] align_sticky(input logic [FW-1:0] v,
                                                   input logic [EXP_W-1:0] d);
        logic [FW-1:0] mask;
        logic [FW-1:0] shifted;
        logic [FW-1:0] res;
        if ({{(32-EXP_W){1'b0}}, d} >= FW) begin
            res = {{(FW-1){1'b0}}, |v};
        end else begin
            mask    = ~({FW{1'b1}} << d);
            shifted = v >> d;
            res     = {shifted[FW-1:1], shifted[0] | (|(v & mask))};
        end
        return res;
    endfunction

    logic vld_p1, vld_p2;
    logic adv_p1, accept;

    assign adv_p1    = vld_p1 && (!vld_p2 || out_ready);
    assign in_ready  = !vld_p1 || adv_p1;
    assign accept    = in_valid && in_ready;
    assign out_valid = vld_p2;

    // Operand decode
    logic             sa, sb, ha, hb;
    logic [EXP_W-1:0] ea, eb, eea, eeb;
    logic [FRAC_W-1:0] fa, fb;
    logic [EXP_W+FRAC_W:0] mag_a, mag_b;
    logic swap, mag_eq, fasu, sb_eff, both_zero, nan_a, nan_b, cancel, rzs;

    assign sa  = opa[W-1];
    assign sb  = opb[W-1];
    assign ea  = opa[W-2:FRAC_W];
    assign eb  = opb[W-2:FRAC_W];
    assign fa  = opa[FRAC_W-1:0];
    assign fb  = opb[FRAC_W-1:0];
    assign ha  = |ea;
    assign hb  = |eb;
    // Denormals share exponent 1 with the smallest normals; the hidden bit
    // then breaks the tie in the magnitude compare.
    assign eea = ha ? ea : {{(EXP_W-1){1'b0}}, 1'b1};
    assign eeb = hb ? eb : {{(EXP_W-1){1'b0}}, 1'b1};
    assign mag_a = {eea, ha, fa};
    assign mag_b = {eeb, hb, fb};
    assign swap   = mag_b > mag_a;
    assign mag_eq = mag_a == mag_b;

    // Subtraction is folded into opb's sign; the operation is an effective
    // addition when both resulting signs agree.
    assign sb_eff    = sb ^ ~add;
    assign fasu      = ~(sa ^ sb_eff);
    assign both_zero = ~|opa[W-2:0] && ~|opb[W-2:0];
    assign nan_a     = (&ea) && (|fa);
    assign nan_b     = (&eb) && (|fb);
    assign cancel    = !fasu && mag_eq;
    assign rzs       = cancel ? (rmode == 2'b11) : (fasu && both_zero && sa);

    // ---- Stage 1: compare / swap ----
    logic [FRAC_W:0]  mant_l_p1, mant_s_p1;
    logic [EXP_W-1:0] exp_l_p1, shift_p1;
    logic             cancel_p1, sign_p1, nan_sign_p1, rzs_p1, fasu_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_p1 <= 1'b0;
        else if (accept)
            vld_p1 <= 1'b1;
        else if (adv_p1)
            vld_p1 <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mant_l_p1   <= swap ? {hb, fb} : {ha, fa};
            mant_s_p1   <= swap ? {ha, fa} : {hb, fb};
            exp_l_p1    <= swap ? eeb : eea;
            shift_p1    <= swap ? (eeb - eea) : (eea - eeb);
            cancel_p1   <= cancel;
            sign_p1     <= swap ? sb_eff : sa;
            nan_sign_p1 <= nan_a ? sa : (nan_b && sb);
            rzs_p1      <= rzs;
            fasu_p1     <= fasu;
        end
    end

    // ---- Stage 2: align ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2           <= 1'b0;
            fracta_out       <= '0;
            fractb_out       <= '0;
            exp_dn_out       <= '0;
            sign             <= 1'b0;
            nan_sign         <= 1'b0;
            result_zero_sign <= 1'b0;
            fasu_op          <= 1'b0;
        end else begin
            if (adv_p1) begin
                vld_p2           <= 1'b1;
                fracta_out       <= {mant_l_p1, 3'b000};
                fractb_out       <= align_sticky({mant_s_p1, 3'b000}, shift_p1);
                exp_dn_out       <= cancel_p1 ? '0 : exp_l_p1;
                sign             <= sign_p1;
                nan_sign         <= nan_sign_p1;
                result_zero_sign <= rzs_p1;
                fasu_op          <= fasu_p1;
            end else if (out_ready) begin
                vld_p2 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pre_norm_pipe.sv
`timescale 1ns/1ps
module tb_pre_norm_pipe;

    logic        clk, rst, in_valid, in_ready, add, out_valid, out_ready;
    logic [31:0] opa, opb;
    logic [1:0]  rmode;
    logic [26:0] fracta_out, fractb_out;
    logic [7:0]  exp_dn_out;
    logic        sign, nan_sign, result_zero_sign, fasu_op;

    pre_norm_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opa(opa), .opb(opb), .add(add), .rmode(rmode),
        .out_valid(out_valid), .out_ready(out_ready),
        .fracta_out(fracta_out), .fractb_out(fractb_out), .exp_dn_out(exp_dn_out),
        .sign(sign), .nan_sign(nan_sign), .result_zero_sign(result_zero_sign),
        .fasu_op(fasu_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [26:0] fa;
        logic [26:0] fb;
        logic [7:0]  ex;
        logic        sg, ns, rz, fo;
    } res_t;

    int n_tests = 0;
    int n_fail  = 0;
    res_t exp_q[$];
    res_t mon_e;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: operands as (effective exponent, integer significand) pairs.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic ad, input logic [1:0] rm);
        res_t   r;
        int     ea, eb, d;
        longint ma, mb, ka, kb, ml, ms, m3;
        logic   a_big, sb_eff, bothz, nana, nanb;
        ea = (a[30:23] == 0) ? 1 : int'(a[30:23]);
        eb = (b[30:23] == 0) ? 1 : int'(b[30:23]);
        ma = longint'(a[22:0]) + ((a[30:23] != 0) ? (longint'(1) << 23) : 0);
        mb = longint'(b[22:0]) + ((b[30:23] != 0) ? (longint'(1) << 23) : 0);
        ka = longint'(ea) * (longint'(1) << 24) + ma;
        kb = longint'(eb) * (longint'(1) << 24) + mb;
        a_big  = (ka >= kb);
        sb_eff = b[31] ^ ~ad;
        r.fo   = (a[31] == sb_eff);
        r.sg   = a_big ? a[31] : sb_eff;
        d      = a_big ? ea - eb : eb - ea;
        ml     = a_big ? ma : mb;
        ms     = a_big ? mb : ma;
        r.fa   = 27'(ml << 3);
        m3     = ms << 3;
        if (d >= 27) begin
            r.fb = (m3 != 0) ? 27'd1 : 27'd0;
        end else begin
            r.fb = 27'(m3 >> d);
            if ((m3 % (longint'(1) << d)) != 0) r.fb[0] = 1'b1;
        end
        bothz = (a[30:0] == 0) && (b[30:0] == 0);
        if (!r.fo && ka == kb) begin
            r.ex = 8'd0;
            r.rz = (rm == 2'b11);
        end else begin
            r.ex = 8'(a_big ? ea : eb);
            r.rz = (r.fo && bothz) ? a[31] : 1'b0;
        end
        nana = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nanb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        r.ns = nana ? a[31] : (nanb ? b[31] : 1'b0);
        return r;
    endfunction

    // Scoreboard: inputs and outputs are stable around the falling edge, so
    // what is seen here is exactly what the next rising edge transfers.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("fracta", fracta_out, mon_e.fa);
                    check("fractb", fractb_out, mon_e.fb);
                    check("exp_dn", exp_dn_out, mon_e.ex);
                    check("sign", sign, mon_e.sg);
                    check("nan_sign", nan_sign, mon_e.ns);
                    check("zero_sign", result_zero_sign, mon_e.rz);
                    check("fasu_op", fasu_op, mon_e.fo);
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(opa, opb, add, rmode));
        end
    end

    // One pair into an idle pipeline with out_ready=1; checks 2-cycle latency.
    task automatic drive_single(input logic [31:0] a, input logic [31:0] b,
                                input logic ad, input logic [1:0] rm);
        opa = a; opb = b; add = ad; rmode = rm; in_valid = 1'b1;
        check("single_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat1_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        check("lat2_out_valid", out_valid, 1'b1);
    endtask

    res_t        snap_r;
    logic [26:0] snap_fa, snap_fb;
    logic [7:0]  snap_ex;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        opa = '0; opb = '0; add = 1'b1; rmode = 2'b00;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_fracta", fracta_out, 27'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Basic add, first accept right after reset release
        drive_single(32'h40000000, 32'h3F800000, 1'b1, 2'b00);
        check("v1_fa", fracta_out, 27'h4000000);
        check("v1_fb", fractb_out, 27'h2000000);
        check("v1_exp", exp_dn_out, 8'h80);
        check("v1_sign", sign, 1'b0);
        check("v1_fasu", fasu_op, 1'b1);

        // Exact cancellation, round toward minus infinity and nearest
        drive_single(32'h3F800000, 32'h3F800000, 1'b0, 2'b11);
        check("v2_exp", exp_dn_out, 8'h00);
        check("v2_rzs", result_zero_sign, 1'b1);
        check("v2_fa", fracta_out, 27'h4000000);
        check("v2_fb", fractb_out, 27'h4000000);
        drive_single(32'h3F800000, 32'h3F800000, 1'b0, 2'b00);
        check("v2b_rzs", result_zero_sign, 1'b0);

        // Large shift with sticky
        drive_single(32'h4B000000, 32'h3F800001, 1'b1, 2'b00);
        check("v3_fb", fractb_out, 27'h0000009);
        check("v3_fa", fracta_out, 27'h4000000);
        check("v3_exp", exp_dn_out, 8'h96);

        // Swap
        drive_single(32'h3F800000, 32'hC0000000, 1'b1, 2'b00);
        check("v4_fa", fracta_out, 27'h4000000);
        check("v4_exp", exp_dn_out, 8'h80);
        check("v4_sign", sign, 1'b1);
        check("v4_fasu", fasu_op, 1'b0);

        // Shift beyond full width: only sticky survives
        drive_single(32'h7F000000, 32'h00000001, 1'b1, 2'b00);
        check("v5_fb", fractb_out, 27'h0000001);
        @(posedge clk); #1;

        // Back-pressure: two accepted, third held off, outputs stable
        out_ready = 1'b0;
        opa = 32'h40400000; opb = 32'h3F000000; add = 1'b1; in_valid = 1'b1;
        snap_r = model(opa, opb, add, rmode);
        @(posedge clk); #1;
        opa = 32'hC1200000; opb = 32'h41200000;
        @(posedge clk); #1;
        opa = 32'h3E800000; opb = 32'hBF800000;
        check("bp_in_ready0", in_ready, 1'b0);
        check("bp_out_valid", out_valid, 1'b1);
        check("bp_fa_first", fracta_out, snap_r.fa);
        check("bp_fb_first", fractb_out, snap_r.fb);
        snap_fa = fracta_out; snap_fb = fractb_out; snap_ex = exp_dn_out;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_ready", in_ready, 1'b0);
            check("bp_hold_fa", fracta_out, snap_fa);
            check("bp_hold_fb", fractb_out, snap_fb);
            check("bp_hold_exp", exp_dn_out, snap_ex);
        end
        out_ready = 1'b1;
        #1 check("bp_release_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("bp_drained", exp_q.size(), 0);

        // Reset with two entries in flight
        out_ready = 1'b0;
        opa = 32'h40000000; opb = 32'h3F800000; add = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        opa = 32'h41000000; opb = 32'h40800000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_fa", fracta_out, 27'd0);
        check("mid_rst_fb", fractb_out, 27'd0);
        check("mid_rst_exp", exp_dn_out, 8'd0);
        check("mid_rst_flags", {sign, nan_sign, result_zero_sign, fasu_op}, 4'd0);
        check("mid_rst_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_stale", out_valid, 1'b0);
        end

        // Randomized traffic with random back-pressure
        for (int c = 0; c < 600; c++) begin
            logic [31:0] a, b;
            logic [7:0]  e2;
            int k;
            k = $urandom_range(0, 7);
            a = $urandom;
            b = $urandom;
            case (k)
                0: b = a;
                1: b = a ^ 32'h80000000;
                2: begin
                    e2 = a[30:23] - 8'($urandom_range(0, 30));
                    b  = {1'($urandom), e2, 23'($urandom)};
                end
                3: begin
                    a = {a[31], 31'd0};
                    b = {1'($urandom), 31'd0};
                end
                4: begin
                    a = {a[31], 8'h00, a[22:0]};
                    b = {b[31], 8'($urandom_range(0, 2)), b[22:0]};
                end
                5: a = {a[31], 8'hFF, ((k & 1) == 1) ? 23'd0 : a[22:0]};
                6: b = {b[31], 8'hFF, b[22:0]};
                default: ;
            endcase
            opa = a; opb = b;
            add = 1'($urandom);
            rmode = 2'($urandom);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        begin
            int guard;
            guard = 0;
            while (exp_q.size() != 0 && guard < 100) begin
                @(posedge clk); #1;
                guard++;
            end
            check("drain_queue_empty", exp_q.size(), 0);
        end
        @(posedge clk); #1;
        check("final_out_valid", out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
